pcm_sram_bridge: RTL

- Responder for the CPU's SRAM-style memory bus: active-low CE/OE/WE/UB/LB strobes, 20-bit address and 16-bit data.
- Converts each CPU access into a single-word access on the PCM buffer memory port: 11-bit address, chipselect, clken, write, byteenable, 16-bit read/write data.
- Sits between the CPU core and the PCM buffer, in place of an external SRAM.
- CPU and memory sides share one clock. Tristate resolution of the CPU data bus happens at top level, driven by cpu_rdata_oe.

---
 rtl/pcm_bridge_pkg.sv | 25 ++
 rtl/pcm_bridge_req_det.sv | 80 ++++++++
 rtl/pcm_sram_bridge.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pcm_bridge_pkg.sv
// Shared types and constants for the PCM SRAM bridge.
package pcm_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_ERR
    } state_t;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } kind_t;

    localparam logic [15:0] ERR_RDATA = 16'hFFFF;
    localparam logic [1:0]  LANE_NONE = 2'b00;

    // Expands the two byte-lane selects into a 16-bit data mask.
    function automatic logic [15:0] lane_mask(input logic [1:0] lanes);
        return {{8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/pcm_bridge_req_det.sv
// Request decode for the PCM bridge: detects a new CPU access, captures its
// fields and implements the SRAM-like arm/re-arm rule.
module pcm_bridge_req_det
    import pcm_bridge_pkg::*;
#(
    parameter int                CPU_AW    = 20,
    parameter int                MEM_AW    = 11,
    parameter int                DW        = 16,
    parameter logic [CPU_AW-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idle,
    input  logic              cpu_ce_n,
    input  logic              cpu_oe_n,
    input  logic              cpu_we_n,
    input  logic              cpu_ub_n,
    input  logic              cpu_lb_n,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              start,
    output kind_t             start_kind,
    output logic              start_in_win,
    output logic [1:0]        start_lanes,
    output logic [MEM_AW-1:0] cap_offset,
    output logic [DW-1:0]     cap_wdata,
    output logic [1:0]        cap_lanes
);

    logic              req;
    logic              armed;
    logic              changed;
    logic [CPU_AW-1:0] offset;
    logic [CPU_AW-1:0] cap_addr;
    logic              cap_we_n;
    logic              cap_oe_n;

    // Live decode of the bus; a write wins when WE and OE are both low.
    always_comb begin
        req          = !cpu_ce_n && (!cpu_we_n || !cpu_oe_n);
        start_kind   = !cpu_we_n ? KIND_WR : KIND_RD;
        start_lanes  = {!cpu_ub_n, !cpu_lb_n};
        offset       = cpu_addr - BASE_ADDR;
        start_in_win = (cpu_addr >= BASE_ADDR) && (offset[CPU_AW-1:MEM_AW] == '0);
        changed      = (cpu_addr != cap_addr) || (cpu_we_n != cap_we_n) || (cpu_oe_n != cap_oe_n);
        start        = idle && req && armed;
    end

    // Armed drops once an access starts and comes back in IDLE when the
    // request goes away or the CPU moves to a different address/kind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b1;
        end else if (start) begin
            armed <= 1'b0;
        end else if (idle && (!req || changed)) begin
            armed <= 1'b1;
        end
    end

    // Snapshot of the access so later bus edits cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_addr   <= '0;
            cap_we_n   <= 1'b1;
            cap_oe_n   <= 1'b1;
            cap_offset <= '0;
            cap_wdata  <= '0;
            cap_lanes  <= LANE_NONE;
        end else if (start) begin
            cap_addr   <= cpu_addr;
            cap_we_n   <= cpu_we_n;
            cap_oe_n   <= cpu_oe_n;
            cap_offset <= offset[MEM_AW-1:0];
            cap_wdata  <= cpu_wdata;
            cap_lanes  <= start_lanes;
        end
    end

endmodule

// File: rtl/pcm_sram_bridge.sv
// CPU SRAM-bus responder that maps a window of the CPU address space onto
// the PCM buffer memory port. Optional statistics counters are built when
// PCM_BRIDGE_STATS_EN is defined.
module pcm_sram_bridge
    import pcm_bridge_pkg::*;
#(
    parameter int                CPU_AW    = 20,
    parameter int                MEM_AW    = 11,
    parameter int                DW        = 16,
    parameter int                RD_LAT    = 1,
    parameter logic [CPU_AW-1:0] BASE_ADDR = 20'h00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce_n,
    input  logic              cpu_oe_n,
    input  logic              cpu_we_n,
    input  logic              cpu_ub_n,
    input  logic              cpu_lb_n,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_rdata_oe,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    output logic [DW-1:0]     mem_writedata,
    input  logic [DW-1:0]     mem_readdata
`ifdef PCM_BRIDGE_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
    output logic [7:0]        stat_err_cnt
`endif
);

    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    state_t            state, state_d;
    logic [1:0]        cnt;
    logic              rd_valid;
    logic              idle;
    logic              start;
    kind_t             start_kind;
    logic              start_in_win;
    logic [1:0]        start_lanes;
    logic [MEM_AW-1:0] cap_offset;
    logic [DW-1:0]     cap_wdata;
    logic [1:0]        cap_lanes;
    logic              rd_done;

    assign idle    = (state == S_IDLE);
    assign rd_done = (state == S_RD_WAIT) && (cnt == 2'd1);

    pcm_bridge_req_det #(
        .CPU_AW    (CPU_AW),
        .MEM_AW    (MEM_AW),
        .DW        (DW),
        .BASE_ADDR (BASE_ADDR)
    ) u_req_det (
        .clk          (clk),
        .reset        (reset),
        .idle         (idle),
        .cpu_ce_n     (cpu_ce_n),
        .cpu_oe_n     (cpu_oe_n),
        .cpu_we_n     (cpu_we_n),
        .cpu_ub_n     (cpu_ub_n),
        .cpu_lb_n     (cpu_lb_n),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .start        (start),
        .start_kind   (start_kind),
        .start_in_win (start_in_win),
        .start_lanes  (start_lanes),
        .cap_offset   (cap_offset),
        .cap_wdata    (cap_wdata),
        .cap_lanes    (cap_lanes)
    );

    // State register and read-latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            if (state == S_RD_ISSUE) begin
                cnt <= RD_LAT_C;
            end else if (state == S_RD_WAIT) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // Next-state decode and memory strobes; zero-lane writes never leave IDLE.
    always_comb begin
        state_d        = state;
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_clken      = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = LANE_NONE;
        mem_writedata  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!start_in_win) begin
                        state_d = S_ERR;
                    end else if (start_kind == KIND_RD) begin
                        state_d = S_RD_ISSUE;
                    end else if (start_lanes != LANE_NONE) begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                mem_address    = cap_offset;
                mem_chipselect = 1'b1;
                mem_clken      = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = cap_lanes;
                mem_writedata  = cap_wdata;
                state_d        = S_IDLE;
            end
            S_RD_ISSUE: begin
                mem_address    = cap_offset;
                mem_chipselect = 1'b1;
                mem_clken      = 1'b1;
                mem_byteenable = 2'b11;
                state_d        = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                mem_address = cap_offset;
                mem_clken   = 1'b1;
                if (cnt == 2'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // CPU-side response: ready/err pulses line up with the WR/ERR cycle, and
    // read data lands together with its ready pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            rd_valid  <= 1'b0;
        end else begin
            cpu_ready <= (start && !(start_in_win && (start_kind == KIND_RD))) || rd_done;
            cpu_err   <= start && !start_in_win;
            if (start) begin
                rd_valid <= !start_in_win && (start_kind == KIND_RD);
                if (!start_in_win) begin
                    cpu_rdata <= ERR_RDATA;
                end
            end else if (rd_done) begin
                rd_valid  <= 1'b1;
                cpu_rdata <= mem_readdata & lane_mask(cap_lanes);
            end
        end
    end

    assign cpu_rdata_oe = rd_valid && !cpu_ce_n && !cpu_oe_n && cpu_we_n;

`ifdef PCM_BRIDGE_STATS_EN
    kind_t done_kind;

    // Remembers the kind of the access whose ready pulse is pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_kind <= KIND_RD;
        end else if (start) begin
            done_kind <= start_kind;
        end
    end

    // Saturating per-kind completion counters; clear beats increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_rd_cnt  <= '0;
            stat_wr_cnt  <= '0;
            stat_err_cnt <= '0;
        end else if (stat_clr) begin
            stat_rd_cnt  <= '0;
            stat_wr_cnt  <= '0;
            stat_err_cnt <= '0;
        end else if (cpu_ready) begin
            if (cpu_err) begin
                if (stat_err_cnt != 8'hFF) stat_err_cnt <= stat_err_cnt + 8'd1;
            end else if (done_kind == KIND_RD) begin
                if (stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end else begin
                if (stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
